// File: rtl/issue_pkg.sv
// Shared definitions for the issue-stage operand unit: forwarding slot
// indexing, stall-cause encoding and helpers.
package issue_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_SB   = 2'd1,
    CAUSE_LU   = 2'd2,
    CAUSE_OCC  = 2'd3
  } stall_cause_e;

  // Flattened producer slot: stage-major, so stage 0 (EX) occupies the low slots.
  function automatic int fwd_slot(input int stage, input int lane, input int lanes);
    return stage * lanes + lane;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/issue_fwd_sel.sv
// Per-source operand select: picks the youngest matching in-flight producer,
// falling back to the register file value.
module issue_fwd_sel
  import issue_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int FWD_STAGES = 3,
  parameter int XLEN       = 32
) (
  input  logic [4:0]                        rs,
  input  logic                              used,
  input  logic [XLEN-1:0]                   rf_data,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_valid,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_we,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_rdy,
  input  logic [5*FWD_STAGES*LANES-1:0]     fwd_rd,
  input  logic [XLEN*FWD_STAGES*LANES-1:0]  fwd_data,
  output logic [XLEN-1:0]                   data,
  output logic                              match,
  output logic                              rdy
);

  // Walk oldest to youngest so the last hit (stage 0, highest lane) sticks.
  always_comb begin
    data  = rf_data;
    match = 1'b0;
    rdy   = 1'b1;
    if (used && (rs != REG_ZERO)) begin
      for (int s = FWD_STAGES - 1; s >= 0; s--) begin
        for (int l = 0; l < LANES; l++) begin
          if (fwd_valid[fwd_slot(s, l, LANES)] && fwd_we[fwd_slot(s, l, LANES)] &&
              (fwd_rd[fwd_slot(s, l, LANES)*5 +: 5] == rs)) begin
            data  = fwd_data[fwd_slot(s, l, LANES)*XLEN +: XLEN];
            match = 1'b1;
            rdy   = fwd_rdy[fwd_slot(s, l, LANES)];
          end
        end
      end
    end
  end

endmodule

// File: rtl/issue_operand_unit.sv
// Issue-stage operand unit: RF read, forwarding, scoreboard/RAW stall and the
// issue-to-EX pipeline register. Optional perf counters under ISSUE_PERF_EN.
module issue_operand_unit
  import issue_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int FWD_STAGES = 3,
  parameter int XLEN       = 32,
  parameter int PAYLOAD_W  = 200
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [4:0]                        in_rs1,
  input  logic [4:0]                        in_rs2,
  input  logic                              in_rs1_used,
  input  logic                              in_rs2_used,
  input  logic [4:0]                        in_rd,
  input  logic                              in_we,
  input  logic                              in_long_lat,
  input  logic [PAYLOAD_W-1:0]              in_payload,
  output logic [4:0]                        rf_raddr0,
  output logic [4:0]                        rf_raddr1,
  input  logic [XLEN-1:0]                   rf_rdata0,
  input  logic [XLEN-1:0]                   rf_rdata1,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_valid,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_we,
  input  logic [FWD_STAGES*LANES-1:0]       fwd_rdy,
  input  logic [5*FWD_STAGES*LANES-1:0]     fwd_rd,
  input  logic [XLEN*FWD_STAGES*LANES-1:0]  fwd_data,
  input  logic                              sb_done_valid,
  input  logic [4:0]                        sb_done_rd,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [XLEN-1:0]                   out_src1,
  output logic [XLEN-1:0]                   out_src2,
  output logic [4:0]                        out_rd,
  output logic                              out_we,
  output logic                              out_long_lat,
  output logic [PAYLOAD_W-1:0]              out_payload,
  output logic [31:0]                       perf_stall_sb,
  output logic [31:0]                       perf_stall_lu,
  output logic [31:0]                       perf_stall_occ
);

  logic [XLEN-1:0] src1_data, src2_data;
  logic            src1_match, src2_match;
  logic            src1_rdy, src2_rdy;
  logic            rs1_live, rs2_live;
  logic            hz_sb, hz_lu, hz_occ;
  logic            stall, accept, handoff;
  logic [31:0]     scoreboard, sb_set, sb_clr, sb_next;

  assign rf_raddr0 = in_rs1;
  assign rf_raddr1 = in_rs2;

  issue_fwd_sel #(
    .LANES      (LANES),
    .FWD_STAGES (FWD_STAGES),
    .XLEN       (XLEN)
  ) u_sel_rs1 (
    .rs        (in_rs1),
    .used      (in_rs1_used),
    .rf_data   (rf_rdata0),
    .fwd_valid (fwd_valid),
    .fwd_we    (fwd_we),
    .fwd_rdy   (fwd_rdy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (src1_data),
    .match     (src1_match),
    .rdy       (src1_rdy)
  );

  issue_fwd_sel #(
    .LANES      (LANES),
    .FWD_STAGES (FWD_STAGES),
    .XLEN       (XLEN)
  ) u_sel_rs2 (
    .rs        (in_rs2),
    .used      (in_rs2_used),
    .rf_data   (rf_rdata1),
    .fwd_valid (fwd_valid),
    .fwd_we    (fwd_we),
    .fwd_rdy   (fwd_rdy),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .data      (src2_data),
    .match     (src2_match),
    .rdy       (src2_rdy)
  );

  assign rs1_live = in_rs1_used && (in_rs1 != REG_ZERO);
  assign rs2_live = in_rs2_used && (in_rs2 != REG_ZERO);

  // The occupant of the pipeline register has not executed yet, so any RAW
  // against it must wait until it reaches a forwarding stage.
  assign hz_sb  = (rs1_live && scoreboard[in_rs1]) || (rs2_live && scoreboard[in_rs2]);
  assign hz_lu  = (src1_match && !src1_rdy) || (src2_match && !src2_rdy);
  assign hz_occ = out_valid && out_we &&
                  ((rs1_live && (out_rd == in_rs1)) || (rs2_live && (out_rd == in_rs2)));

  assign stall    = in_valid && (hz_sb || hz_lu || hz_occ);
  assign in_ready = !stall && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      out_src1     <= '0;
      out_src2     <= '0;
      out_rd       <= '0;
      out_we       <= 1'b0;
      out_long_lat <= 1'b0;
      out_payload  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_src1     <= src1_data;
        out_src2     <= src2_data;
        out_rd       <= in_rd;
        out_we       <= in_we;
        out_long_lat <= in_long_lat;
        out_payload  <= in_payload;
      end
    end
  end

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (handoff && out_we && out_long_lat && (out_rd != REG_ZERO)) begin
      sb_set[out_rd] = 1'b1;
    end
    if (sb_done_valid) begin
      sb_clr[sb_done_rd] = 1'b1;
    end
  end

  // Set applied after clear so a same-cycle set of the same register wins.
  assign sb_next = ((scoreboard & ~sb_clr) | sb_set) & ~32'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scoreboard <= '0;
    end else begin
      scoreboard <= sb_next;
    end
  end

`ifdef ISSUE_PERF_EN
  stall_cause_e cause;
  logic [31:0]  cnt_sb, cnt_lu, cnt_occ;

  always_comb begin
    cause = CAUSE_NONE;
    if (in_valid) begin
      if (hz_sb) begin
        cause = CAUSE_SB;
      end else if (hz_lu) begin
        cause = CAUSE_LU;
      end else if (hz_occ) begin
        cause = CAUSE_OCC;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_sb  <= '0;
      cnt_lu  <= '0;
      cnt_occ <= '0;
    end else begin
      if (cause == CAUSE_SB)  cnt_sb  <= sat_inc(cnt_sb);
      if (cause == CAUSE_LU)  cnt_lu  <= sat_inc(cnt_lu);
      if (cause == CAUSE_OCC) cnt_occ <= sat_inc(cnt_occ);
    end
  end

  assign perf_stall_sb  = cnt_sb;
  assign perf_stall_lu  = cnt_lu;
  assign perf_stall_occ = cnt_occ;
`else
  assign perf_stall_sb  = '0;
  assign perf_stall_lu  = '0;
  assign perf_stall_occ = '0;
`endif

endmodule

// File: tb/tb_issue_operand_unit.sv
// Directed bench for issue_operand_unit: forwarding priority, load-use,
// scoreboard, occupancy, hold, flush and async reset.
module tb_issue_operand_unit;

`ifdef ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk, resetn;
  logic         in_valid, in_ready;
  logic [4:0]   in_rs1, in_rs2, in_rd;
  logic         in_rs1_used, in_rs2_used, in_we, in_long_lat;
  logic [199:0] in_payload;
  logic [4:0]   rf_raddr0, rf_raddr1;
  logic [31:0]  rf_rdata0, rf_rdata1;
  logic [5:0]   fwd_valid, fwd_we, fwd_rdy;
  logic [29:0]  fwd_rd;
  logic [191:0] fwd_data;
  logic         sb_done_valid;
  logic [4:0]   sb_done_rd;
  logic         flush;
  logic         out_valid, out_ready;
  logic [31:0]  out_src1, out_src2;
  logic [4:0]   out_rd;
  logic         out_we, out_long_lat;
  logic [199:0] out_payload;
  logic [31:0]  perf_stall_sb, perf_stall_lu, perf_stall_occ;

  int checks = 0;
  int errors = 0;

  issue_operand_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rs1_used    (in_rs1_used),
    .in_rs2_used    (in_rs2_used),
    .in_rd          (in_rd),
    .in_we          (in_we),
    .in_long_lat    (in_long_lat),
    .in_payload     (in_payload),
    .rf_raddr0      (rf_raddr0),
    .rf_raddr1      (rf_raddr1),
    .rf_rdata0      (rf_rdata0),
    .rf_rdata1      (rf_rdata1),
    .fwd_valid      (fwd_valid),
    .fwd_we         (fwd_we),
    .fwd_rdy        (fwd_rdy),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .sb_done_valid  (sb_done_valid),
    .sb_done_rd     (sb_done_rd),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_src1       (out_src1),
    .out_src2       (out_src2),
    .out_rd         (out_rd),
    .out_we         (out_we),
    .out_long_lat   (out_long_lat),
    .out_payload    (out_payload),
    .perf_stall_sb  (perf_stall_sb),
    .perf_stall_lu  (perf_stall_lu),
    .perf_stall_occ (perf_stall_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid    = 1'b0;
    in_rs1      = 5'd0;
    in_rs2      = 5'd0;
    in_rs1_used = 1'b0;
    in_rs2_used = 1'b0;
    in_rd       = 5'd0;
    in_we       = 1'b0;
    in_long_lat = 1'b0;
    in_payload  = '0;
  endtask

  task automatic clr_fwd();
    fwd_valid = '0;
    fwd_we    = '0;
    fwd_rdy   = '0;
    fwd_rd    = '0;
    fwd_data  = '0;
  endtask

  task automatic set_fwd(input int slot, input logic [4:0] rd, input logic [31:0] data,
                         input logic rdy, input logic we);
    fwd_valid[slot]         = 1'b1;
    fwd_we[slot]            = we;
    fwd_rdy[slot]           = rdy;
    fwd_rd[slot*5 +: 5]     = rd;
    fwd_data[slot*32 +: 32] = data;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we,
                       input logic ll, input logic [199:0] pl);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs1_used = u1;
    in_rs2      = rs2;
    in_rs2_used = u2;
    in_rd       = rd;
    in_we       = we;
    in_long_lat = ll;
    in_payload  = pl;
  endtask

  initial begin
    resetn = 1'b0; out_ready = 1'b1; flush = 1'b0;
    sb_done_valid = 1'b0; sb_done_rd = 5'd0;
    rf_rdata0 = 32'h0; rf_rdata1 = 32'h0;
    clr_in();
    clr_fwd();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_src1", out_src1, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_perf_sb", perf_stall_sb, 0);
    resetn = 1'b1;

    // youngest producer of r3 is stage0 lane1
    rf_rdata0 = 32'h11; rf_rdata1 = 32'h99;
    set_fwd(2, 5'd3, 32'h22, 1'b1, 1'b1);
    set_fwd(1, 5'd3, 32'h33, 1'b1, 1'b1);
    issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 200'hABC123);
    #1;
    chk("fwd_raddr0", rf_raddr0, 3);
    chk("fwd_in_ready", in_ready, 1);
    tick();
    chk("fwd_out_valid", out_valid, 1);
    chk("fwd_src1", out_src1, 32'h33);
    chk("fwd_src2_rf", out_src2, 32'h99);
    chk("fwd_out_rd", out_rd, 10);
    chk("fwd_payload", out_payload, 200'hABC123);
    clr_in(); clr_fwd();
    tick();
    chk("drain_out_valid", out_valid, 0);

    // stage priority over lane, lane priority within stage, we=0 ignored
    set_fwd(5, 5'd7, 32'h75, 1'b1, 1'b1);
    set_fwd(2, 5'd7, 32'h20, 1'b1, 1'b1);
    set_fwd(3, 5'd7, 32'h21, 1'b1, 1'b1);
    set_fwd(4, 5'd12, 32'hC0, 1'b1, 1'b1);
    set_fwd(0, 5'd7, 32'hDEAD, 1'b1, 1'b0);
    issue(5'd7, 1'b1, 5'd12, 1'b1, 5'd20, 1'b1, 1'b0, 200'h2);
    #1;
    chk("prio_in_ready", in_ready, 1);
    tick();
    chk("prio_src1", out_src1, 32'h21);
    chk("prio_src2", out_src2, 32'hC0);

    // load-use on r5
    clr_fwd();
    rf_rdata1 = 32'h123;
    set_fwd(0, 5'd5, 32'hBAD, 1'b0, 1'b1);
    issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 200'h3);
    #1;
    chk("lu_in_ready", in_ready, 0);
    tick();
    chk("lu_no_accept", out_valid, 0);
    chk("lu_perf", perf_stall_lu, PERF ? 32'd1 : 32'd0);
    clr_fwd();
    set_fwd(2, 5'd5, 32'h55, 1'b1, 1'b1);
    #1;
    chk("lu_release_ready", in_ready, 1);
    tick();
    chk("lu_src2", out_src2, 32'h55);
    chk("lu_out_rd", out_rd, 6);

    // occupant writes r6, consumer reads r6
    clr_fwd();
    issue(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 200'h4);
    #1;
    chk("occ_in_ready", in_ready, 0);
    tick();
    chk("occ_drained", out_valid, 0);
    chk("occ_perf", perf_stall_occ, PERF ? 32'd1 : 32'd0);
    clr_in();

    // hold stable under backpressure
    out_ready = 1'b0;
    rf_rdata0 = 32'hA1; rf_rdata1 = 32'hA2;
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd17, 1'b1, 1'b0, 200'h5);
    #1;
    chk("hold_first_ready", in_ready, 1);
    tick();
    chk("hold_out_valid", out_valid, 1);
    rf_rdata0 = 32'hB1;
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd18, 1'b1, 1'b0, 200'h6);
    #1;
    chk("hold_backpressure", in_ready, 0);
    tick();
    chk("hold_rd", out_rd, 17);
    chk("hold_src1", out_src1, 32'hA1);
    out_ready = 1'b1;
    #1;
    chk("hold_release_ready", in_ready, 1);
    tick();
    chk("hold_next_rd", out_rd, 18);
    chk("hold_next_src1", out_src1, 32'hB1);
    clr_in();
    tick();

    // long-latency r8: 10 stall cycles, sb_done in the 10th
    rf_rdata0 = 32'h88;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 200'h7);
    tick();
    chk("div_long_lat", out_long_lat, 1);
    clr_in();
    tick();
    chk("div_handed_off", out_valid, 0);
    issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd21, 1'b0, 1'b0, 200'h8);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("sb_stall", in_ready, 0);
      tick();
    end
    sb_done_valid = 1'b1; sb_done_rd = 5'd8;
    #1;
    chk("sb_no_bypass", in_ready, 0);
    tick();
    sb_done_valid = 1'b0;
    #1;
    chk("sb_cleared_ready", in_ready, 1);
    tick();
    chk("sb_accept", out_valid, 1);
    chk("sb_src1", out_src1, 32'h88);
    chk("sb_perf", perf_stall_sb, PERF ? 32'd10 : 32'd0);
    clr_in();
    tick();

    // same-cycle set and clear of r9: set wins
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 200'h9);
    tick();
    clr_in();
    sb_done_valid = 1'b1; sb_done_rd = 5'd9;
    tick();
    sb_done_valid = 1'b0;
    issue(5'd0, 1'b0, 5'd9, 1'b1, 5'd22, 1'b0, 1'b0, 200'hA);
    #1;
    chk("sb_set_wins", in_ready, 0);
    sb_done_valid = 1'b1; sb_done_rd = 5'd9;
    tick();
    sb_done_valid = 1'b0;
    #1;
    chk("sb9_cleared", in_ready, 1);
    tick();
    chk("sb9_accept", out_valid, 1);
    chk("sb9_perf", perf_stall_sb, PERF ? 32'd11 : 32'd0);
    clr_in();
    tick();

    // r0 consumer and unused rs matching pending r4
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 200'hB);
    tick();
    clr_in();
    tick();
    set_fwd(0, 5'd4, 32'hBAD, 1'b0, 1'b1);
    set_fwd(1, 5'd0, 32'hFFFF, 1'b1, 1'b1);
    rf_rdata0 = 32'h44; rf_rdata1 = 32'h0;
    issue(5'd4, 1'b0, 5'd0, 1'b1, 5'd23, 1'b1, 1'b0, 200'hC);
    #1;
    chk("r0_unused_ready", in_ready, 1);
    tick();
    chk("unused_src1_rf", out_src1, 32'h44);
    chk("r0_src2_zero", out_src2, 32'h0);
    chk("r0_out_valid", out_valid, 1);

    // flush beats accept, scoreboard retained
    clr_fwd();
    out_ready = 1'b0;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd24, 1'b1, 1'b0, 200'hD);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_out_valid", out_valid, 0);
    flush = 1'b0; out_ready = 1'b1;
    issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd25, 1'b0, 1'b0, 200'hE);
    #1;
    chk("flush_sb_kept", in_ready, 0);
    sb_done_valid = 1'b1; sb_done_rd = 5'd4;
    tick();
    sb_done_valid = 1'b0;
    #1;
    chk("flush_sb4_cleared", in_ready, 1);
    tick();
    chk("flush_next_accept", out_rd, 25);
    chk("final_perf_sb", perf_stall_sb, PERF ? 32'd12 : 32'd0);
    chk("final_perf_lu", perf_stall_lu, PERF ? 32'd1 : 32'd0);
    chk("final_perf_occ", perf_stall_occ, PERF ? 32'd1 : 32'd0);
    clr_in();
    tick();

    // async reset during a scoreboard stall
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 200'hF);
    tick();
    clr_in();
    tick();
    issue(5'd13, 1'b1, 5'd0, 1'b0, 5'd26, 1'b0, 1'b0, 200'h10);
    #1;
    chk("rst_mid_stall", in_ready, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_perf", perf_stall_sb, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("rst_sb_cleared", in_ready, 1);
    tick();
    chk("rst_reissue", out_rd, 26);
    clr_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
